tempo_tick_gen: RTL and testbench

TEMPO_TICK_GEN -- requirements
Module: tempo_tick_gen

---
 rtl/tempo_tick_gen_if.sv | 52 +++++
 rtl/tempo_tick_gen.sv | 160 ++++++++++++++++
 tb/tb_tempo_tick_gen.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tempo_tick_gen_if.sv
// ---------------------------------------------------------------------------
// tempo_tick_gen_if -- control/status bundle for the tempo tick generator.
//
// Signals (directions seen from the generator, i.e. the slave modport):
//   start      in   pulse: begin or restart tick generation
//   stop       in   pulse: halt generation, return to idle
//   pause      in   level: freeze timing while high
//   period     in   W    : requested tick period in clk cycles (0 acts as 1)
//   period_wr  in   pulse: capture period into the shadow register
//   swing      in   W    : swing amount (only with TEMPO_TICK_GEN_SWING_EN)
//   tick       out  one-cycle pulse per period
//   restart    out  one-cycle pulse following every accepted start
//   running    out  high while generating (RUN or HOLD)
//
// The master modport is for whoever drives the controls (sequencer, bench).
// Optional feature macro: TEMPO_TICK_GEN_SWING_EN
// ---------------------------------------------------------------------------
interface tempo_tick_gen_if #(
    parameter int W = 16
);
    logic         start;
    logic         stop;
    logic         pause;
    logic [W-1:0] period;
    logic         period_wr;
`ifdef TEMPO_TICK_GEN_SWING_EN
    logic [W-1:0] swing;
`endif
    logic         tick;
    logic         restart;
    logic         running;

`ifdef TEMPO_TICK_GEN_SWING_EN
    modport master (
        output start, stop, pause, period, period_wr, swing,
        input  tick, restart, running
    );
    modport slave (
        input  start, stop, pause, period, period_wr, swing,
        output tick, restart, running
    );
`else
    modport master (
        output start, stop, pause, period, period_wr,
        input  tick, restart, running
    );
    modport slave (
        input  start, stop, pause, period, period_wr,
        output tick, restart, running
    );
`endif
endinterface

// File: rtl/tempo_tick_gen.sv
// ---------------------------------------------------------------------------
// tempo_tick_gen -- programmable tempo tick generator.
//
// Produces a one-cycle tick every len clk cycles while running, plus a
// one-cycle restart pulse after every start, intended to drive the ce and
// load of a downstream step counter.  A shadow period register can be written
// at any time; the active period follows it continuously while idle and
// otherwise only at a tick boundary, so a gap in progress is never stretched
// or cut short.
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous, active-high reset
//   bus   tempo_tick_gen_if.slave (start/stop/pause/period/period_wr[/swing]
//         in, tick/restart/running out)
//
// Optional feature macro: TEMPO_TICK_GEN_SWING_EN
//   Adds a swing input.  Alternate gaps become per_act+swing and
//   per_act-swing (swing clamped to per_act-1), so each pair still spans
//   2*per_act cycles.  Without the macro every gap is per_act.
// ---------------------------------------------------------------------------
module tempo_tick_gen #(
    parameter int W = 16
) (
    input  logic            clk,
    input  logic            rst,
    tempo_tick_gen_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [W-1:0] ONE    = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W:0]   ONE_W1 = {{W{1'b0}}, 1'b1};

    state_t       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] shadow_q, shadow_d;
    logic [W-1:0] per_act_q, per_act_d;
    logic         parity_q, parity_d;
    logic         tick_q, tick_d;
    logic         restart_q, restart_d;
    logic         running_q, running_d;

    logic [W:0]   len;
    logic [W:0]   len_m1;
    logic [W-1:0] cnt_last;
    logic         counting;
    logic         at_end;
    logic         load_act;

    // A period of 0 behaves as 1 (tick every cycle).
    function automatic logic [W-1:0] norm_period(input logic [W-1:0] p);
        return (p == '0) ? ONE : p;
    endfunction

`ifdef TEMPO_TICK_GEN_SWING_EN
    logic [W-1:0] swing_act_q, swing_act_d;

    // Swing may never reach per_act, otherwise the short gap would be <= 0.
    function automatic logic [W-1:0] clamp_swing(input logic [W-1:0] s,
                                                 input logic [W-1:0] p);
        return (s > p - ONE) ? (p - ONE) : s;
    endfunction

    assign len = parity_q ? ({1'b0, per_act_q} - {1'b0, swing_act_q})
                          : ({1'b0, per_act_q} + {1'b0, swing_act_q});
`else
    assign len = {1'b0, per_act_q};
`endif

    // len can exceed the counter range with a large swing; saturate the
    // terminal count so cnt never has to leave W bits.
    assign len_m1   = len - ONE_W1;
    assign cnt_last = len_m1[W] ? {W{1'b1}} : len_m1[W-1:0];
    assign counting = (state_q != IDLE) && !bus.pause;
    assign at_end   = counting && (cnt_q == cnt_last);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        parity_d  = parity_q;
        tick_d    = 1'b0;
        restart_d = 1'b0;
        per_act_d = per_act_q;
        shadow_d  = bus.period_wr ? norm_period(bus.period) : shadow_q;

        if (bus.stop) begin
            // stop wins over start and swallows a tick due on this edge
            state_d  = IDLE;
            cnt_d    = '0;
            parity_d = 1'b0;
        end else if (bus.start) begin
            // start wins over pause; HOLD follows next edge if pause stays high
            state_d   = RUN;
            cnt_d     = '0;
            parity_d  = 1'b0;
            restart_d = 1'b1;
        end else if (state_q != IDLE) begin
            if (bus.pause) begin
                state_d = HOLD;
            end else begin
                // the HOLD->RUN edge counts, so a pause of N cycles adds N
                state_d = RUN;
                if (at_end) begin
                    cnt_d    = '0;
                    parity_d = ~parity_q;
                    tick_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
        end

        // shadow_d (not shadow_q) so a write on a boundary edge takes effect
        load_act = (state_q == IDLE) || tick_d;
        if (load_act) begin
            per_act_d = shadow_d;
        end
        running_d = (state_d != IDLE);
    end

`ifdef TEMPO_TICK_GEN_SWING_EN
    assign swing_act_d = load_act ? clamp_swing(bus.swing, shadow_d) : swing_act_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            parity_q    <= 1'b0;
            shadow_q    <= ONE;
            per_act_q   <= ONE;
            tick_q      <= 1'b0;
            restart_q   <= 1'b0;
            running_q   <= 1'b0;
`ifdef TEMPO_TICK_GEN_SWING_EN
            swing_act_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            parity_q    <= parity_d;
            shadow_q    <= shadow_d;
            per_act_q   <= per_act_d;
            tick_q      <= tick_d;
            restart_q   <= restart_d;
            running_q   <= running_d;
`ifdef TEMPO_TICK_GEN_SWING_EN
            swing_act_q <= swing_act_d;
`endif
        end
    end

    assign bus.tick    = tick_q;
    assign bus.restart = restart_q;
    assign bus.running = running_q;
endmodule

// File: tb/tb_tempo_tick_gen.sv
// ---------------------------------------------------------------------------
// tb_tempo_tick_gen -- self-checking bench for tempo_tick_gen.
// Directed scenarios check tick/restart/running against hand-derived cycle
// numbers (cycle 1 = the cycle the restart pulse is visible); a randomized
// run is checked against an interval-countdown reference model.
// ---------------------------------------------------------------------------
module tb_tempo_tick_gen;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tempo_tick_gen_if #(.W(W)) bus();

    tempo_tick_gen #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    // Tracks cycles remaining in the current gap rather than a count-up.
    bit m_run;
    bit m_par;
    int m_rem;
    int m_sh;
    int m_per;
    int m_sw;
    bit e_tick;
    bit e_restart;
    bit e_running;

    function automatic int m_len();
        return m_par ? (m_per - m_sw) : (m_per + m_sw);
    endfunction

    function automatic int m_clamp(input int s, input int p);
        return (s > p - 1) ? (p - 1) : s;
    endfunction

    task automatic model_reset();
        m_run = 0; m_par = 0; m_rem = 0;
        m_sh = 1; m_per = 1; m_sw = 0;
        e_tick = 0; e_restart = 0; e_running = 0;
    endtask

    task automatic model_edge();
        int  sh_new;
        int  sw_in;
        bit  was_idle;
        was_idle = !m_run;
        sh_new = bus.period_wr ? ((bus.period == '0) ? 1 : int'(bus.period)) : m_sh;
`ifdef TEMPO_TICK_GEN_SWING_EN
        sw_in = int'(bus.swing);
`else
        sw_in = 0;
`endif
        e_tick = 0;
        e_restart = 0;
        if (was_idle) begin
            m_per = sh_new;
            m_sw  = m_clamp(sw_in, sh_new);
        end
        if (bus.stop) begin
            m_run = 0;
        end else if (bus.start) begin
            m_run = 1;
            m_par = 0;
            e_restart = 1;
            m_rem = m_len();
        end else if (m_run && !bus.pause) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                e_tick = 1;
                m_per  = sh_new;
                m_sw   = m_clamp(sw_in, sh_new);
                m_par  = !m_par;
                m_rem  = m_len();
            end
        end
        m_sh = sh_new;
        e_running = m_run;
    endtask

    // one clock edge; model sees the same inputs as the DUT; sample at +1
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        bus.start = 0; bus.stop = 0; bus.pause = 0;
        bus.period = '0; bus.period_wr = 0;
`ifdef TEMPO_TICK_GEN_SWING_EN
        bus.swing = '0;
`endif
    endtask

    // return to idle and write a period, leaving a couple of idle cycles
    task automatic prep(input int per);
        bus.stop = 1; step(); bus.stop = 0;
        bus.period = W'(per); bus.period_wr = 1; step(); bus.period_wr = 0;
        step();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", bus.tick); end
        n_checks++;
        if (bus.restart !== 1'b0) begin n_fail++; $display("FAIL reset_restart: got %b want 0", bus.restart); end
        n_checks++;
        if (bus.running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b want 0", bus.running); end
        #3 rst = 0;
    endtask

    task automatic test_basic();
        prep(4);
        bus.start = 1; step(); bus.start = 0;
        n_checks++;
        if (bus.restart !== 1'b1) begin n_fail++; $display("FAIL basic_restart: got %b want 1", bus.restart); end
        n_checks++;
        if (bus.running !== 1'b1) begin n_fail++; $display("FAIL basic_running: got %b want 1", bus.running); end
        for (int k = 2; k <= 14; k++) begin
            bit exp_t;
            step();
            exp_t = (k == 5 || k == 9 || k == 13);
            n_checks++;
            if (bus.tick !== exp_t || bus.restart !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_tick cyc %0d: got tick=%b restart=%b want tick=%b restart=0",
                         k, bus.tick, bus.restart, exp_t);
            end
        end
    endtask

    task automatic test_period_change();
        prep(4);
        bus.start = 1; step(); bus.start = 0;
        for (int k = 2; k <= 22; k++) begin
            bit exp_t;
            if (k == 7) begin bus.period = W'(6); bus.period_wr = 1; end
            step();
            bus.period_wr = 0;
            exp_t = (k == 5 || k == 9 || k == 15 || k == 21);
            n_checks++;
            if (bus.tick !== exp_t) begin
                n_fail++;
                $display("FAIL period_change cyc %0d: got %b want %b", k, bus.tick, exp_t);
            end
        end
    endtask

    task automatic test_pause();
        prep(4);
        bus.start = 1; step(); bus.start = 0;
        for (int k = 2; k <= 17; k++) begin
            bit exp_t;
            bus.pause = (k >= 8 && k <= 10);
            step();
            exp_t = (k == 5 || k == 12 || k == 16);
            n_checks++;
            if (bus.tick !== exp_t || bus.running !== 1'b1) begin
                n_fail++;
                $display("FAIL pause cyc %0d: got tick=%b running=%b want tick=%b running=1",
                         k, bus.tick, bus.running, exp_t);
            end
        end
        bus.pause = 0;
    endtask

    task automatic test_stop_start();
        prep(4);
        bus.start = 1; step(); bus.start = 0;
        repeat (3) step();
        bus.stop = 1; bus.start = 1; step(); bus.stop = 0; bus.start = 0;
        n_checks++;
        if (bus.tick !== 1'b0 || bus.restart !== 1'b0 || bus.running !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_start edge: got tick=%b restart=%b running=%b want 0 0 0",
                     bus.tick, bus.restart, bus.running);
        end
        for (int k = 0; k < 6; k++) begin
            step();
            n_checks++;
            if (bus.tick !== 1'b0 || bus.running !== 1'b0) begin
                n_fail++;
                $display("FAIL stop_idle cyc %0d: got tick=%b running=%b want 0 0", k, bus.tick, bus.running);
            end
        end
    endtask

    task automatic test_zero_and_rst();
        prep(0);
        bus.start = 1; step(); bus.start = 0;
        n_checks++;
        if (bus.restart !== 1'b1 || bus.tick !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_restart: got restart=%b tick=%b want 1 0", bus.restart, bus.tick);
        end
        for (int k = 2; k <= 8; k++) begin
            step();
            n_checks++;
            if (bus.tick !== 1'b1) begin n_fail++; $display("FAIL zero_tick cyc %0d: got %b want 1", k, bus.tick); end
        end
        // reset between edges: outputs must drop without waiting for a clock
        #2 rst = 1;
        model_reset();
        #1;
        n_checks++;
        if (bus.tick !== 1'b0 || bus.restart !== 1'b0 || bus.running !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst: got tick=%b restart=%b running=%b want 0 0 0",
                     bus.tick, bus.restart, bus.running);
        end
        #1 rst = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            n_checks++;
            if (bus.tick !== 1'b0 || bus.restart !== 1'b0 || bus.running !== 1'b0) begin
                n_fail++;
                $display("FAIL post_rst cyc %0d: got tick=%b restart=%b running=%b want 0 0 0",
                         k, bus.tick, bus.restart, bus.running);
            end
        end
    endtask

`ifdef TEMPO_TICK_GEN_SWING_EN
    task automatic test_swing();
        bus.swing = W'(2);
        prep(8);
        bus.start = 1; step(); bus.start = 0;
        for (int k = 2; k <= 34; k++) begin
            bit exp_t;
            step();
            exp_t = (k == 11 || k == 17 || k == 27 || k == 33);
            n_checks++;
            if (bus.tick !== exp_t) begin n_fail++; $display("FAIL swing2 cyc %0d: got %b want %b", k, bus.tick, exp_t); end
        end
        bus.swing = W'(20);
        prep(8);
        bus.start = 1; step(); bus.start = 0;
        for (int k = 2; k <= 34; k++) begin
            bit exp_t;
            step();
            exp_t = (k == 16 || k == 17 || k == 32 || k == 33);
            n_checks++;
            if (bus.tick !== exp_t) begin n_fail++; $display("FAIL swing_clamp cyc %0d: got %b want %b", k, bus.tick, exp_t); end
        end
        bus.swing = '0;
    endtask
`endif

    task automatic test_random();
        #2 rst = 1;
        model_reset();
        #2 rst = 0;
        clear_inputs();
        for (int k = 0; k < 800; k++) begin
            bus.start     = ($urandom_range(0, 24) == 0);
            bus.stop      = ($urandom_range(0, 59) == 0);
            bus.pause     = ($urandom_range(0, 6) == 0);
            bus.period_wr = ($urandom_range(0, 9) == 0);
            bus.period    = W'($urandom_range(0, 6));
`ifdef TEMPO_TICK_GEN_SWING_EN
            bus.swing     = W'($urandom_range(0, 7));
`endif
            step();
            n_checks++;
            if (bus.tick !== e_tick || bus.restart !== e_restart || bus.running !== e_running) begin
                n_fail++;
                $display("FAIL random cyc %0d: got tick=%b restart=%b running=%b want %b %b %b",
                         k, bus.tick, bus.restart, bus.running, e_tick, e_restart, e_running);
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_basic();
        test_period_change();
        test_pause();
        test_stop_start();
        test_zero_and_rst();
`ifdef TEMPO_TICK_GEN_SWING_EN
        test_swing();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end
endmodule
